// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam logic OVL_ON   = 1'b1;
  localparam logic OVL_OFF  = 1'b0;
  localparam int   PLEN_MAX = 16;

  // Width needed to hold a fill count from 0 up to and including plen.
  function automatic int fill_w(input int plen);
    return $clog2(plen + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones and never wraps.
module sat_counter #(
  parameter int W = 4
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 q <= '0;
    else if (clr)              q <= '0;
    else if (inc && !(&q))     q <= q + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable PLEN-bit serial pattern detector with registered match pulse,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PLEN = 4,
  parameter int CW   = 4,
  parameter int FW   = fill_w(PLEN)
)(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            x,
  input  logic            clr,
  input  logic [PLEN-1:0] pat,
  input  logic            ovl,
  output logic            z,
  output logic [CW-1:0]   count,
  output logic [FW-1:0]   fill
);

  localparam logic [FW-1:0] FILL_MAX = FW'(PLEN);
  localparam logic [FW-1:0] FILL_ARM = FW'(PLEN - 1);

  logic [PLEN-1:0] hist, hist_sh, hist_nx;
  logic [FW-1:0]   fill_nx;
  logic            match;

  // fill gates the compare so stale zeros from reset/clr never form a match.
  always_comb begin
    hist_sh = {hist[PLEN-2:0], x};
    hist_nx = hist;
    fill_nx = fill;
    match   = 1'b0;
    if (en) begin
      hist_nx = hist_sh;
      match   = (hist_sh == pat) && (fill >= FILL_ARM);
      if (match && (ovl == OVL_OFF)) fill_nx = '0;
      else if (fill != FILL_MAX)     fill_nx = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      z    <= 1'b0;
    end else begin
      hist <= hist_nx;
      fill <= fill_nx;
      z    <= match;
    end
  end

  sat_counter #(.W(CW)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (match),
    .q     (count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param (PLEN=4; CW=4 and CW=2 instances).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, en, x, clr, ovl;
  logic [3:0] pat;
  logic       z, z2;
  logic [3:0] count;
  logic [1:0] count2;
  logic [2:0] fill, fill2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PLEN(4), .CW(4)) dut (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr), .pat(pat), .ovl(ovl),
    .z(z), .count(count), .fill(fill)
  );

  seq_detector_param #(.PLEN(4), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .x(x), .clr(clr), .pat(pat), .ovl(ovl),
    .z(z2), .count(count2), .fill(fill2)
  );

  typedef struct {
    logic       clr, en, x;
    logic [3:0] pat;
    logic       ovl;
    logic       ez;
    int         ecnt, ecnt2, efill;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic addv(input logic c, input logic e, input logic b, input logic [3:0] p,
                      input logic o, input logic ez, input int ec, input int ec2, input int ef);
    vec_t v;
    v.clr = c; v.en = e; v.x = b; v.pat = p; v.ovl = o;
    v.ez = ez; v.ecnt = ec; v.ecnt2 = ec2; v.efill = ef;
    vq.push_back(v);
  endtask

  task automatic step(input logic c, input logic e, input logic b);
    clr = c; en = e; x = b;
    @(posedge clk); #1;
  endtask

  task automatic chk_all(input string nm, input logic ez, input int ec, input int ef);
    chk({nm, " z"}, 32'(z), 32'(ez));
    chk({nm, " count"}, 32'(count), ec);
    chk({nm, " fill"}, 32'(fill), ef);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; x = 1'b0; clr = 1'b0; ovl = 1'b1; pat = 4'b1011;

    // A: overlapping 1011 on 1,0,1,1,0,1,1
    addv(1,1,1,4'b1011,1, 0,0,0,0);
    addv(0,1,1,4'b1011,1, 0,0,0,1);
    addv(0,1,0,4'b1011,1, 0,0,0,2);
    addv(0,1,1,4'b1011,1, 0,0,0,3);
    addv(0,1,1,4'b1011,1, 1,1,1,4);
    addv(0,1,0,4'b1011,1, 0,1,1,4);
    addv(0,1,1,4'b1011,1, 0,1,1,4);
    addv(0,1,1,4'b1011,1, 1,2,2,4);
    // B: same stream, non-overlapping
    addv(1,0,0,4'b1011,0, 0,0,0,0);
    addv(0,1,1,4'b1011,0, 0,0,0,1);
    addv(0,1,0,4'b1011,0, 0,0,0,2);
    addv(0,1,1,4'b1011,0, 0,0,0,3);
    addv(0,1,1,4'b1011,0, 1,1,1,0);
    addv(0,1,0,4'b1011,0, 0,1,1,1);
    addv(0,1,1,4'b1011,0, 0,1,1,2);
    addv(0,1,1,4'b1011,0, 0,1,1,3);
    // C: pattern 0000 must not match on cleared history until fill is full
    addv(1,0,0,4'b0000,1, 0,0,0,0);
    addv(0,1,0,4'b0000,1, 0,0,0,1);
    addv(0,1,0,4'b0000,1, 0,0,0,2);
    addv(0,1,0,4'b0000,1, 0,0,0,3);
    addv(0,1,0,4'b0000,1, 1,1,1,4);
    addv(0,1,0,4'b0000,1, 1,2,2,4);
    addv(0,1,0,4'b0000,1, 1,3,3,4);
    // D: en gap in the middle of a pattern
    addv(1,0,0,4'b1011,1, 0,0,0,0);
    addv(0,1,1,4'b1011,1, 0,0,0,1);
    addv(0,1,0,4'b1011,1, 0,0,0,2);
    addv(0,0,0,4'b1011,1, 0,0,0,2);
    addv(0,0,0,4'b1011,1, 0,0,0,2);
    addv(0,0,0,4'b1011,1, 0,0,0,2);
    addv(0,1,1,4'b1011,1, 0,0,0,3);
    addv(0,1,1,4'b1011,1, 1,1,1,4);
    // E: 9 zeros, 6 matches; CW=2 counter saturates at 3
    addv(1,0,0,4'b0000,1, 0,0,0,0);
    for (int k = 1; k <= 9; k++)
      addv(0,1,0,4'b0000,1, k >= 4, (k >= 4) ? k-3 : 0,
           (k >= 6) ? 3 : ((k >= 4) ? k-3 : 0), (k >= 4) ? 4 : k);

    #2;
    chk_all("reset", 1'b0, 0, 0);
    chk("reset count2", 32'(count2), 0);
    @(negedge clk); reset = 1'b0;

    foreach (vq[i]) begin
      pat = vq[i].pat; ovl = vq[i].ovl;
      step(vq[i].clr, vq[i].en, vq[i].x);
      chk_all($sformatf("v%0d", i), vq[i].ez, vq[i].ecnt, vq[i].efill);
      chk($sformatf("v%0d count2", i), 32'(count2), vq[i].ecnt2);
    end

    // Async reset between edges, straight after a match
    pat = 4'b1011; ovl = 1'b1;
    step(1,0,0);
    step(0,1,1); step(0,1,0); step(0,1,1); step(0,1,1);
    chk_all("pre-reset", 1'b1, 1, 4);
    reset = 1'b1; #2;
    chk_all("async reset", 1'b0, 0, 0);
    reset = 1'b0;
    step(0,1,1);
    chk_all("post-reset bit", 1'b0, 0, 1);
    step(0,1,0); step(0,1,1); step(0,1,1);
    chk_all("post-reset match", 1'b1, 1, 4);

    // clr wins over a completing bit
    step(0,1,1); step(0,1,0); step(0,1,1);
    chk_all("pre-clr", 1'b0, 1, 4);
    step(1,1,1);
    chk_all("clr over match", 1'b0, 0, 0);
    step(0,0,0);
    chk_all("after clr idle", 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
